// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, opcode encodings and instruction field positions.
package proc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned NREGS  = 1 << REG_AW;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned IMM_W  = 8;

  // Instruction layout: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt / [7:0] imm8
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS_LSB  = 4;
  localparam int unsigned RT_LSB  = 0;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_SHL = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND = 4'b0011;
  localparam logic [OP_W-1:0] OP_LDI = 4'b1000;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL) ||
           (op == OP_AND) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 16x16 register file: two combinational read ports, a debug read port and one synchronous write port.
module regfile_2r1w
  import proc_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra0_i,
  output logic [DATA_W-1:0] rd0_o,
  input  logic [REG_AW-1:0] ra1_i,
  output logic [DATA_W-1:0] rd1_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else if (we_i && !(ZERO_R0 && (wa_i == '0))) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // R0 is masked on read as well so it is hard zero regardless of storage.
  always_comb begin
    rd0_o      = (ZERO_R0 && (ra0_i == '0))      ? '0 : mem_q[ra0_i];
    rd1_o      = (ZERO_R0 && (ra1_i == '0))      ? '0 : mem_q[ra1_i];
    dbg_data_o = (ZERO_R0 && (dbg_addr_i == '0)) ? '0 : mem_q[dbg_addr_i];
  end

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around the external ALU: decode, operand forwarding, pipeline registers,
// register-file writeback and retire/illegal status.
module alu_issue_wb
  import proc_pkg::*;
#(
  parameter bit          ZERO_R0 = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   Opcode,
  input  logic [DATA_W-1:0] Output,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  retired,
  output logic              illegal
);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   opc_q, opc_d;
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              illegal_q, illegal_d;

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd, rs, rt;
  logic [IMM_W-1:0]  imm8;
  logic [DATA_W-1:0] rf_rs, rf_rt, src_a, src_b;
  logic              accept, fwd_ok;

  assign instr_ready = ~rst;
  assign accept      = instr_valid & instr_ready;

  assign op   = instr[OP_LSB +: OP_W];
  assign rd   = instr[RD_LSB +: REG_AW];
  assign rs   = instr[RS_LSB +: REG_AW];
  assign rt   = instr[RT_LSB +: REG_AW];
  assign imm8 = instr[IMM_LSB +: IMM_W];

  regfile_2r1w #(.ZERO_R0(ZERO_R0)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .ra0_i      (rs),
    .rd0_o      (rf_rs),
    .ra1_i      (rt),
    .rd1_o      (rf_rt),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
    .we_i       (ex_valid_q),
    .wa_i       (ex_rd_q),
    .wd_i       (Output)
  );

  // The in-flight ALU result bypasses the register file; hard-zero R0 is never a forwarding source.
  assign fwd_ok = ex_valid_q && !(ZERO_R0 && (ex_rd_q == '0));
  assign src_a  = (fwd_ok && (ex_rd_q == rs)) ? Output : rf_rs;
  assign src_b  = (fwd_ok && (ex_rd_q == rt)) ? Output : rf_rt;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    opc_d      = opc_q;
    ex_valid_d = 1'b0;
    ex_rd_d    = ex_rd_q;
    wb_valid_d = ex_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    retired_d  = retired_q;
    illegal_d  = illegal_q;

    if (accept) begin
      if (!op_is_legal(op)) begin
        illegal_d = 1'b1;
      end else begin
        ex_valid_d = 1'b1;
        ex_rd_d    = rd;
        if (op == OP_LDI) begin
          a_d   = '0;
          b_d   = DATA_W'(imm8);
          opc_d = OP_ADD;
        end else begin
          a_d   = src_a;
          b_d   = src_b;
          opc_d = op;
        end
      end
    end

    if (ex_valid_q) begin
      wb_addr_d = ex_rd_q;
      wb_data_d = Output;
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      opc_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      retired_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      opc_q      <= opc_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      retired_q  <= retired_d;
      illegal_q  <= illegal_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign Opcode   = opc_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign retired  = retired_q;
  assign illegal  = illegal_q;

endmodule
